// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative signed restoring divider for MIPS DIV (HI=remainder, LO=quotient)
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             w_DivStart,
    input  logic [WIDTH-1:0] w_A,
    input  logic [WIDTH-1:0] w_B,
    output logic             w_DivStop,
    output logic             w_DivZero,
    output logic [WIDTH-1:0] w_DIVHI,
    output logic [WIDTH-1:0] w_DIVLO
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_n;

    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dsr;
    logic             sign_q;
    logic             sign_r;
    logic             zero_case;

    logic             b_is_zero;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] diff;
    logic             trial_ok;

    // Magnitudes are unsigned, so the most negative operand becomes 2^(WIDTH-1) cleanly.
    assign b_is_zero = (w_B == '0);
    assign a_mag     = w_A[WIDTH-1] ? (~w_A + 1'b1) : w_A;
    assign b_mag     = w_B[WIDTH-1] ? (~w_B + 1'b1) : w_B;

    assign rem_sh    = {rem, quo[WIDTH-1]};
    assign diff      = rem_sh - {2'b00, dsr};
    assign trial_ok  = ~diff[WIDTH+1];

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (w_DivStart) begin
                    state_n = b_is_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (count == CW'(1)) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            count     <= '0;
            rem       <= '0;
            quo       <= '0;
            dsr       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            zero_case <= 1'b0;
            w_DivStop <= 1'b0;
            w_DivZero <= 1'b0;
            w_DIVHI   <= '0;
            w_DIVLO   <= '0;
        end else begin
            state     <= state_n;
            w_DivStop <= 1'b0;
            case (state)
                IDLE: begin
                    if (w_DivStart) begin
                        w_DivZero <= b_is_zero;
                        zero_case <= b_is_zero;
                        if (!b_is_zero) begin
                            sign_q <= w_A[WIDTH-1] ^ w_B[WIDTH-1];
                            sign_r <= w_A[WIDTH-1];
                            quo    <= a_mag;
                            dsr    <= b_mag;
                            rem    <= '0;
                            count  <= CW'(WIDTH);
                        end
                    end
                end
                RUN: begin
                    rem   <= trial_ok ? diff[WIDTH:0] : rem_sh[WIDTH:0];
                    quo   <= {quo[WIDTH-2:0], trial_ok};
                    count <= count - 1'b1;
                end
                DONE: begin
                    w_DivStop <= 1'b1;
                    // A divide-by-zero leaves the previous HI/LO visible to software.
                    if (!zero_case) begin
                        w_DIVLO <= sign_q ? (~quo + 1'b1) : quo;
                        w_DIVHI <= sign_r ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

    logic        Clock;
    logic        Reset;
    logic        w_DivStart;
    logic [31:0] w_A;
    logic [31:0] w_B;
    logic        w_DivStop;
    logic        w_DivZero;
    logic [31:0] w_DIVHI;
    logic [31:0] w_DIVLO;

    int checks = 0;
    int errors = 0;

    int          lat, lat2, pulses;
    logic [31:0] lo1, hi1;
    logic        z1, z_after_start;

    div_unit #(.WIDTH(32)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .w_DivStart (w_DivStart),
        .w_A        (w_A),
        .w_B        (w_B),
        .w_DivStop  (w_DivStop),
        .w_DivZero  (w_DivZero),
        .w_DIVHI    (w_DIVHI),
        .w_DIVLO    (w_DIVLO)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // mode 0: plain divide; 1: extra start (9/3) at clock 10; 2: reset at clock 10;
    // 3: second divide (a2/b2) started while the first stop pulse is high.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int mode,
                          input logic [31:0] a2, input logic [31:0] b2);
        @(negedge Clock);
        w_A = a;
        w_B = b;
        w_DivStart = 1'b1;
        @(posedge Clock);
        #1;
        z_after_start = w_DivZero;
        w_DivStart = 1'b0;
        w_A = 32'hDEADBEEF;
        w_B = 32'h0;
        lat = -1;
        lat2 = -1;
        pulses = 0;
        lo1 = 'x;
        hi1 = 'x;
        z1 = 1'bx;
        for (int k = 1; k <= 70; k++) begin
            @(negedge Clock);
            w_DivStart = 1'b0;
            Reset = 1'b0;
            if (k == 10 && mode == 1) begin
                w_A = 32'd9;
                w_B = 32'd3;
                w_DivStart = 1'b1;
            end
            if (k == 10 && mode == 2) Reset = 1'b1;
            if (k == 34 && mode == 3) begin
                w_A = a2;
                w_B = b2;
                w_DivStart = 1'b1;
            end
            @(posedge Clock);
            #1;
            if (w_DivStop) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    lo1 = w_DIVLO;
                    hi1 = w_DIVHI;
                    z1 = w_DivZero;
                end else if (lat2 < 0) begin
                    lat2 = k;
                end
            end
        end
    endtask

    task automatic normal(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        do_div(a, b, 0, 32'h0, 32'h0);
        check({tag, "_lat"}, 32'(lat), 32'd33);
        check({tag, "_pulses"}, 32'(pulses), 32'd1);
        check({tag, "_lo"}, lo1, exp_lo);
        check({tag, "_hi"}, hi1, exp_hi);
        check({tag, "_zero"}, {31'b0, z1}, 32'd0);
    endtask

    initial begin
        Reset = 1'b1;
        w_DivStart = 1'b0;
        w_A = '0;
        w_B = '0;
        repeat (2) @(posedge Clock);
        #1;
        check("rst_stop", {31'b0, w_DivStop}, 32'd0);
        check("rst_zero", {31'b0, w_DivZero}, 32'd0);
        check("rst_hi", w_DIVHI, 32'd0);
        check("rst_lo", w_DIVLO, 32'd0);
        @(negedge Clock);
        Reset = 1'b0;

        normal("u100_7", 32'd100, 32'd7, 32'd14, 32'd2);
        normal("m7_2", 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
        normal("7_m2", 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
        normal("m7_m2", 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF);

        // Divide-by-zero after a 100/7 preload.
        normal("pre", 32'd100, 32'd7, 32'd14, 32'd2);
        do_div(32'd5, 32'd0, 0, 32'h0, 32'h0);
        check("dz_lat", 32'(lat), 32'd1);
        check("dz_pulses", 32'(pulses), 32'd1);
        check("dz_zero", {31'b0, z1}, 32'd1);
        check("dz_hi", hi1, 32'd2);
        check("dz_lo", lo1, 32'd14);
        check("dz_hold", {31'b0, w_DivZero}, 32'd1);
        normal("after_dz", 32'd0, 32'd5, 32'd0, 32'd0);
        check("dz_clear", {31'b0, z_after_start}, 32'd0);

        normal("ovf", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
        normal("min_1", 32'h80000000, 32'd1, 32'h80000000, 32'd0);
        normal("max_min", 32'h7FFFFFFF, 32'h80000000, 32'd0, 32'h7FFFFFFF);

        // Start while busy is ignored.
        do_div(32'd100, 32'd7, 1, 32'h0, 32'h0);
        check("busy_lat", 32'(lat), 32'd33);
        check("busy_pulses", 32'(pulses), 32'd1);
        check("busy_lo", lo1, 32'd14);
        check("busy_hi", hi1, 32'd2);

        // Reset mid-run aborts.
        do_div(32'd100, 32'd7, 2, 32'h0, 32'h0);
        check("abort_pulses", 32'(pulses), 32'd0);
        check("abort_hi", w_DIVHI, 32'd0);
        check("abort_lo", w_DIVLO, 32'd0);
        check("abort_zero", {31'b0, w_DivZero}, 32'd0);
        normal("post_rst", 32'd100, 32'd7, 32'd14, 32'd2);

        // Back-to-back: 100/7 then 1000/-33 (= -30 r 10).
        do_div(32'd100, 32'd7, 3, 32'd1000, 32'hFFFFFFDF);
        check("b2b_lat1", 32'(lat), 32'd33);
        check("b2b_lo1", lo1, 32'd14);
        check("b2b_hi1", hi1, 32'd2);
        check("b2b_lat2", 32'(lat2), 32'd67);
        check("b2b_pulses", 32'(pulses), 32'd2);
        check("b2b_lo2", w_DIVLO, 32'hFFFFFFE2);
        check("b2b_hi2", w_DIVHI, 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative signed 32-bit divider for the MIPS datapath. It is the inverse companion of the Booth multiplier and serves DIV.
- Start/stop pulse handshake is identical to the multiplier's. Writes remainder to HI and quotient to LO, as the HI/LO register file expects.
- Uses restoring division on operand magnitudes, one quotient bit per clock, then applies sign correction.
- Flags divide-by-zero for the exception logic.

Parameters:
- WIDTH, 32, operand/result width. Iteration count equals WIDTH.

Ports:
- Clock  input  1  system clock, rising-edge active
- Reset  input  1  synchronous, active-high reset
- w_DivStart  input  1  one-cycle pulse; operands latched on this edge
- w_A  input  WIDTH  dividend, two's complement
- w_B  input  WIDTH  divisor, two's complement
- w_DivStop  output  1  one-cycle completion pulse
- w_DivZero  output  1  divide-by-zero flag, valid with w_DivStop
- w_DIVHI  output  WIDTH  remainder
- w_DIVLO  output  WIDTH  quotient

Behaviour:
- Reset (synchronous, active-high):
  - All outputs go to 0, FSM goes to IDLE, internal regs are cleared.
  - Reset has priority over w_DivStart in the same cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If w_DivStart=1 and w_B=0: go to DONE, w_DivZero<=1, w_DIVHI/w_DIVLO unchanged.
  - If w_DivStart=1 and w_B!=0: latch the following, set count=WIDTH, go to RUN.
    - sign_q = A[31]^B[31]
    - sign_r = A[31]
    - |A| into Q, |B| into M
    - R = 0 (33 bits)
- RUN, each cycle:
  - {R,Q} shifted left by 1.
  - trial = R - {1'b0,M}.
  - If trial >= 0: R = trial and Q[0] = 1. Else Q[0] = 0.
  - count decrements. When count reaches 0, go to DONE.
- DONE (one cycle):
  - w_DIVLO = sign_q ? -Q : Q.
  - w_DIVHI = sign_r ? -R[31:0] : R[31:0].
  - w_DivZero = 0 for a normal divide.
  - w_DivStop = 1 for exactly this cycle, then return to IDLE.
- Latency:
  - Start sampled at edge E0. Normal divide: w_DivStop high in the cycle after edge E33, i.e. 33 clocks after start. Divide-by-zero: high after edge E1.
- Results:
  - w_DIVHI/w_DIVLO hold their value until the next normal completion or Reset.
  - w_DivZero holds until the next w_DivStart is accepted.
- Semantics: quotient truncates toward zero; remainder takes the sign of the dividend (MIPS DIV).
- Magnitude of 0x80000000 is 2^31 and is handled as unsigned 32-bit in Q/M.
- Overflow case 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No flag is raised.
- w_DivStart while in RUN or DONE is ignored. The operation in progress is unaffected and no restart occurs.
- Changes on w_A/w_B after the start edge have no effect.
- Reset mid-RUN aborts: no w_DivStop pulse, outputs are cleared to 0.
- Dividend 0 with divisor nonzero gives LO=0, HI=0 with normal latency.

Test Plan:
- Unsigned basic: A=100, B=7, start pulse -> w_DivStop exactly 33 clocks later for 1 cycle; LO=14, HI=2, DivZero=0.
- Negative dividend and sign rules:
  - A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - A=7, B=-2 -> LO=0xFFFFFFFD, HI=1.
  - A=-7, B=-2 -> LO=3, HI=0xFFFFFFFF.
- Divide-by-zero: preload HI/LO with 100/7, then A=5, B=0 -> w_DivStop 1 clock after start, DivZero=1, HI=2, LO=14 unchanged; next accepted start clears DivZero.
- Overflow/extremes:
  - A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
  - A=0x80000000, B=1 -> LO=0x80000000, HI=0.
  - A=0x7FFFFFFF, B=0x80000000 -> LO=0, HI=0x7FFFFFFF.
- Busy/abort:
  - Second start at clock 10 of a 100/7 divide (with A=9, B=3) is ignored -> results 14/2 at clock 33.
  - Separately, Reset asserted at clock 10 -> no w_DivStop, all outputs 0.
  - A new start after reset completes normally.
- Back-to-back: start issued the cycle after w_DivStop -> accepted; second result correct at 33 clocks; no lost or duplicate stop pulses.
